// File: rtl/register_pkg.sv
// register_pkg: shared lane-level symbol codes, ordered-set types and training-set field record
//   k_symbols_e   : 8b/10b K-code byte values
//   os_type_e     : ordered-set kinds reported to the LTSSM
//   TS1_ID/TS2_ID : training-set identifier data symbols
//   ts_fields_t   : one training set's type and fields, used for repeat detection
package register_pkg;

    typedef enum logic [7:0] {
        K_SKP = 8'h1C,
        K_FTS = 8'h3C,
        K_SDP = 8'h5C,
        K_IDL = 8'h7C,
        K_COM = 8'hBC,
        K_PAD = 8'hF7,
        K_STP = 8'hFB,
        K_EIE = 8'hFC,
        K_END = 8'hFD,
        K_EDB = 8'hFE
    } k_symbols_e;

    typedef enum logic [2:0] {
        OS_NONE,
        OS_TS1,
        OS_TS2,
        OS_SKP,
        OS_EIOS,
        OS_FTS
    } os_type_e;

    localparam logic [7:0] TS1_ID = 8'h4A;
    localparam logic [7:0] TS2_ID = 8'h45;

    typedef struct packed {
        os_type_e    ts_type;
        logic [7:0]  link_num;
        logic        link_pad;
        logic [7:0]  lane_num;
        logic        lane_pad;
        logic [7:0]  n_fts;
        logic [7:0]  rate_id;
        logic [7:0]  train_ctrl;
    } ts_fields_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TYPE,
        ST_TS_BODY,
        ST_SKP,
        ST_EIOS_BODY,
        ST_FTS_BODY
    } rx_os_state_e;

endpackage

// File: rtl/rx_ordered_set_detector_ts_consec_counter.sv
// ts_consec_counter: counts consecutive identical training sets, saturating
//   clk, rst_n : clock, async active-low reset
//   ts_done    : a TS completed this cycle, ts holds its type and fields
//   clear      : malformed set aborted; count returns to 0
//   cnt        : consecutive identical TS count
module ts_consec_counter
    import register_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ts_done,
    input  logic         clear,
    input  ts_fields_t   ts,
    output logic [W-1:0] cnt
);

    ts_fields_t last;

    // last resets with ts_type=OS_NONE, so the first TS never matches it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= '0;
            cnt  <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (ts_done) begin
            last <= ts;
            cnt  <= (ts != last) ? W'(1) : (&cnt) ? cnt : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rx_ordered_set_detector.sv
// rx_ordered_set_detector: single-lane Gen1/Gen2 ordered-set parser (TS1/TS2/SKP/EIOS/FTS)
//   rx_valid/rx_data/rx_is_k/rx_code_err : decoded symbol stream from the 8b/10b decoder
//   os_valid/os_type                     : completion pulse and held set type
//   ts_*                                 : fields of the last completed TS
//   skp_count                            : SKP symbols in the last SKP set
//   os_err                               : malformed-set abort pulse
//   ts_consec_cnt                        : consecutive identical TS count
module rx_ordered_set_detector
    import register_pkg::*;
#(
    parameter int MAX_SKP  = 5,
    parameter int CONSEC_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    input  logic                rx_is_k,
    input  logic                rx_code_err,
    output logic                os_valid,
    output os_type_e            os_type,
    output logic [7:0]          ts_link_num,
    output logic                ts_link_pad,
    output logic [7:0]          ts_lane_num,
    output logic                ts_lane_pad,
    output logic [7:0]          ts_n_fts,
    output logic [7:0]          ts_rate_id,
    output logic [7:0]          ts_train_ctrl,
    output logic [2:0]          skp_count,
    output logic                os_err,
    output logic [CONSEC_W-1:0] ts_consec_cnt
);

    localparam logic [2:0] SKP_MAX = 3'(MAX_SKP);

    rx_os_state_e state, state_n;
    logic [3:0]   idx, idx_n;
    logic [2:0]   skp_cnt, skp_cnt_n;
    logic [7:0]   link_num, lane_num, n_fts, rate_id, train_ctrl, ts_id;
    logic         link_pad, lane_pad;
    logic         done, err, ts_ok, ts_done;
    os_type_e     done_type;
    ts_fields_t   key;

    wire com_k  = rx_is_k && rx_data == K_COM;
    wire is_com = com_k && !rx_code_err;
    wire is_pad = rx_is_k && rx_data == K_PAD;
    wire is_skp = rx_is_k && rx_data == K_SKP;
    wire is_idl = rx_is_k && rx_data == K_IDL;
    wire is_fts = rx_is_k && rx_data == K_FTS;

    // symbol check for the current TS body position
    assign ts_ok = !rx_code_err && (
        idx == 4'd2 ? (!rx_is_k || is_pad) :
        idx <  4'd6 ? !rx_is_k :
        idx == 4'd6 ? (!rx_is_k && (rx_data == TS1_ID || rx_data == TS2_ID)) :
                      (!rx_is_k && rx_data == ts_id));

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        skp_cnt_n = skp_cnt;
        done      = 1'b0;
        done_type = OS_NONE;
        err       = 1'b0;
        if (rx_valid) begin
            case (state)
                ST_IDLE: if (com_k) state_n = ST_TYPE;
                ST_TYPE: begin
                    if (rx_code_err) err = 1'b1;
                    else if (is_skp) begin
                        state_n   = ST_SKP;
                        skp_cnt_n = 3'd1;
                    end else if (is_idl) begin
                        state_n = ST_EIOS_BODY;
                        idx_n   = 4'd2;
                    end else if (is_fts) begin
                        state_n = ST_FTS_BODY;
                        idx_n   = 4'd2;
                    end else if (!rx_is_k || is_pad) begin
                        state_n = ST_TS_BODY;
                        idx_n   = 4'd2;
                    end else err = 1'b1;
                end
                ST_TS_BODY: begin
                    if (!ts_ok) err = 1'b1;
                    else if (idx == 4'd15) begin
                        done      = 1'b1;
                        done_type = (ts_id == TS1_ID) ? OS_TS1 : OS_TS2;
                        state_n   = ST_IDLE;
                    end else idx_n = idx + 4'd1;
                end
                ST_EIOS_BODY, ST_FTS_BODY: begin
                    if (rx_code_err || !(state == ST_EIOS_BODY ? is_idl : is_fts)) err = 1'b1;
                    else if (idx == 4'd3) begin
                        done      = 1'b1;
                        done_type = (state == ST_EIOS_BODY) ? OS_EIOS : OS_FTS;
                        state_n   = ST_IDLE;
                    end else idx_n = idx + 4'd1;
                end
                ST_SKP: begin
                    if (rx_code_err) err = 1'b1;
                    else if (is_skp) begin
                        if (skp_cnt == SKP_MAX) err = 1'b1;
                        else skp_cnt_n = skp_cnt + 3'd1;
                    end else begin
                        // terminating symbol also starts the next set if it is a COM
                        done      = 1'b1;
                        done_type = OS_SKP;
                        state_n   = is_com ? ST_TYPE : ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
            if (err) state_n = is_com ? ST_TYPE : ST_IDLE;
        end
    end

    assign ts_done = done && (done_type == OS_TS1 || done_type == OS_TS2);

    always_comb begin
        key            = '0;
        key.ts_type    = done_type;
        key.link_num   = link_num;
        key.link_pad   = link_pad;
        key.lane_num   = lane_num;
        key.lane_pad   = lane_pad;
        key.n_fts      = n_fts;
        key.rate_id    = rate_id;
        key.train_ctrl = train_ctrl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            idx           <= '0;
            skp_cnt       <= '0;
            link_num      <= '0;
            link_pad      <= 1'b0;
            lane_num      <= '0;
            lane_pad      <= 1'b0;
            n_fts         <= '0;
            rate_id       <= '0;
            train_ctrl    <= '0;
            ts_id         <= '0;
            os_valid      <= 1'b0;
            os_err        <= 1'b0;
            os_type       <= OS_NONE;
            ts_link_num   <= '0;
            ts_link_pad   <= 1'b0;
            ts_lane_num   <= '0;
            ts_lane_pad   <= 1'b0;
            ts_n_fts      <= '0;
            ts_rate_id    <= '0;
            ts_train_ctrl <= '0;
            skp_count     <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            skp_cnt  <= skp_cnt_n;
            os_valid <= done;
            os_err   <= err;
            if (rx_valid && state == ST_TYPE) begin
                link_num <= rx_data;
                link_pad <= is_pad;
            end
            if (rx_valid && state == ST_TS_BODY) begin
                case (idx)
                    4'd2: begin
                        lane_num <= rx_data;
                        lane_pad <= is_pad;
                    end
                    4'd3: n_fts      <= rx_data;
                    4'd4: rate_id    <= rx_data;
                    4'd5: train_ctrl <= rx_data;
                    4'd6: ts_id      <= rx_data;
                    default: ;
                endcase
            end
            if (done) begin
                os_type <= done_type;
                if (done_type == OS_SKP) skp_count <= skp_cnt;
                if (ts_done) begin
                    ts_link_num   <= link_num;
                    ts_link_pad   <= link_pad;
                    ts_lane_num   <= lane_num;
                    ts_lane_pad   <= lane_pad;
                    ts_n_fts      <= n_fts;
                    ts_rate_id    <= rate_id;
                    ts_train_ctrl <= train_ctrl;
                end
            end
        end
    end

    ts_consec_counter #(.W(CONSEC_W)) u_consec (
        .clk     (clk),
        .rst_n   (rst_n),
        .ts_done (ts_done),
        .clear   (err),
        .ts      (key),
        .cnt     (ts_consec_cnt)
    );

endmodule

// File: tb/tb_rx_ordered_set_detector.sv
// tb_rx_ordered_set_detector: scoreboard bench for rx_ordered_set_detector
module tb_rx_ordered_set_detector;
    import register_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_is_k = 1'b0;
    logic       rx_code_err = 1'b0;
    logic       os_valid, os_err, ts_link_pad, ts_lane_pad;
    os_type_e   os_type;
    logic [7:0] ts_link_num, ts_lane_num, ts_n_fts, ts_rate_id, ts_train_ctrl;
    logic [2:0] skp_count;
    logic [3:0] ts_consec_cnt;

    rx_ordered_set_detector #(.MAX_SKP(5), .CONSEC_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_is_k       (rx_is_k),
        .rx_code_err   (rx_code_err),
        .os_valid      (os_valid),
        .os_type       (os_type),
        .ts_link_num   (ts_link_num),
        .ts_link_pad   (ts_link_pad),
        .ts_lane_num   (ts_lane_num),
        .ts_lane_pad   (ts_lane_pad),
        .ts_n_fts      (ts_n_fts),
        .ts_rate_id    (ts_rate_id),
        .ts_train_ctrl (ts_train_ctrl),
        .skp_count     (skp_count),
        .os_err        (os_err),
        .ts_consec_cnt (ts_consec_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         e;
        os_type_e   t;
        logic [7:0] ln;
        logic       lp;
        logic [7:0] la;
        logic       lap;
        logic [7:0] nf, rt, ct;
        logic [2:0] sk;
        logic [3:0] c;
    } exp_t;

    exp_t q[$];
    exp_t h;
    int   n_chk = 0;
    int   n_fail = 0;

    logic       sk_a[16];
    logic [7:0] sd_a[16];
    logic       ce_a[16];
    logic       b_lp, b_lap;
    logic [7:0] b_l, b_la, b_nf, b_rt, b_ct, b_id;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        n_chk++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, a, x);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (os_valid || os_err)) begin
            if (q.size() == 0) chk("unexpected_output", {os_valid, os_err}, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("os_err", 32'(os_err), 32'(e.e));
                chk("os_valid", 32'(os_valid), 32'(!e.e));
                chk("os_type", 32'(os_type), 32'(e.t));
                chk("link_num", 32'(ts_link_num), 32'(e.ln));
                chk("link_pad", 32'(ts_link_pad), 32'(e.lp));
                chk("lane_num", 32'(ts_lane_num), 32'(e.la));
                chk("lane_pad", 32'(ts_lane_pad), 32'(e.lap));
                chk("n_fts", 32'(ts_n_fts), 32'(e.nf));
                chk("rate_id", 32'(ts_rate_id), 32'(e.rt));
                chk("train_ctrl", 32'(ts_train_ctrl), 32'(e.ct));
                chk("skp_count", 32'(skp_count), 32'(e.sk));
                chk("consec", 32'(ts_consec_cnt), 32'(e.c));
            end
        end
    end

    task automatic sym(input logic k, input logic [7:0] d, input logic ce);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_is_k = k;
        rx_data = d;
        rx_code_err = ce;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_code_err = 1'b0;
        end
    endtask

    task automatic build(input logic lp, input logic [7:0] l, input logic lap, input logic [7:0] la,
                         input logic [7:0] nf, input logic [7:0] rt, input logic [7:0] ct, input logic [7:0] id);
        b_lp = lp; b_l = l; b_lap = lap; b_la = la; b_nf = nf; b_rt = rt; b_ct = ct; b_id = id;
        for (int i = 0; i < 16; i++) begin
            sk_a[i] = 1'b0;
            ce_a[i] = 1'b0;
            sd_a[i] = id;
        end
        sk_a[0] = 1'b1; sd_a[0] = 8'hBC;
        sk_a[1] = lp;   sd_a[1] = lp ? 8'hF7 : l;
        sk_a[2] = lap;  sd_a[2] = lap ? 8'hF7 : la;
        sd_a[3] = nf; sd_a[4] = rt; sd_a[5] = ct;
    endtask

    task automatic send_range(input int a, input int b, input int g);
        for (int i = a; i <= b; i++) begin
            sym(sk_a[i], sd_a[i], ce_a[i]);
            if (g > 0 && i < b) gap(g);
        end
    endtask

    task automatic push_ts(input logic [3:0] c);
        exp_t r;
        h.t = (b_id == 8'h4A) ? OS_TS1 : OS_TS2;
        h.ln = b_lp ? 8'hF7 : b_l; h.lp = b_lp;
        h.la = b_lap ? 8'hF7 : b_la; h.lap = b_lap;
        h.nf = b_nf; h.rt = b_rt; h.ct = b_ct;
        r = h; r.e = 1'b0; r.c = c;
        q.push_back(r);
    endtask

    task automatic push_os(input os_type_e t, input logic [2:0] s, input logic [3:0] c);
        exp_t r;
        h.t = t;
        if (t == OS_SKP) h.sk = s;
        r = h; r.e = 1'b0; r.c = c;
        q.push_back(r);
    endtask

    task automatic push_err();
        exp_t r;
        r = h; r.e = 1'b1; r.c = 4'd0;
        q.push_back(r);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(os_valid), 0);
        chk({tag, "_err"}, 32'(os_err), 0);
        chk({tag, "_type"}, 32'(os_type), 32'(OS_NONE));
        chk({tag, "_fields"}, {ts_link_num, ts_lane_num, ts_n_fts, ts_rate_id}, 0);
        chk({tag, "_misc"}, {ts_train_ctrl, ts_link_pad, ts_lane_pad, skp_count, ts_consec_cnt}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        h = '{e:1'b0, t:OS_NONE, ln:8'h0, lp:1'b0, la:8'h0, lap:1'b0, nf:8'h0, rt:8'h0, ct:8'h0, sk:3'd0, c:4'd0};
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        gap(2);

        build(0, 8'h01, 0, 8'h00, 8'hFF, 8'h02, 8'h00, 8'h4A);
        for (int r = 0; r < 16; r++) begin
            push_ts(r < 15 ? 4'(r + 1) : 4'd15);
            send_range(0, 15, 0);
        end
        gap(1);

        build(1, 8'h00, 1, 8'h00, 8'h10, 8'h02, 8'h00, 8'h45);
        push_ts(4'd1);
        send_range(0, 15, 0);
        build(0, 8'h01, 0, 8'h00, 8'hFF, 8'h02, 8'h00, 8'h4A);
        push_ts(4'd1);
        send_range(0, 15, 0);

        push_os(OS_SKP, 3'd3, 4'd1);
        push_ts(4'd2);
        sym(1, 8'hBC, 0);
        repeat (3) sym(1, 8'h1C, 0);
        send_range(0, 15, 0);
        gap(1);

        sym(1, 8'hBC, 0);
        repeat (5) sym(1, 8'h1C, 0);
        push_err();
        sym(1, 8'h1C, 0);
        gap(2);

        push_os(OS_EIOS, 3'd0, 4'd0);
        sym(1, 8'hBC, 0);
        repeat (3) sym(1, 8'h7C, 0);
        push_os(OS_FTS, 3'd0, 4'd0);
        sym(1, 8'hBC, 0);
        repeat (3) sym(1, 8'h3C, 0);
        gap(1);

        push_os(OS_EIOS, 3'd0, 4'd0);
        sym(1, 8'hBC, 0); gap(1);
        sym(1, 8'h7C, 0); gap(2);
        sym(1, 8'h7C, 0); gap(3);
        sym(1, 8'h7C, 0);
        gap(1);
        push_ts(4'd1);
        send_range(0, 15, 2);
        gap(2);

        build(0, 8'h01, 0, 8'h00, 8'hFF, 8'h02, 8'h00, 8'h4A);
        sd_a[9] = 8'h4B;
        push_err();
        send_range(0, 9, 0);
        gap(2);

        build(0, 8'h01, 0, 8'h00, 8'hFF, 8'h02, 8'h00, 8'h4A);
        ce_a[4] = 1'b1;
        push_err();
        send_range(0, 4, 0);
        gap(2);

        build(0, 8'h01, 0, 8'h00, 8'hFF, 8'h02, 8'h00, 8'h4A);
        sk_a[7] = 1'b1; sd_a[7] = 8'hBC;
        push_err();
        send_range(0, 7, 0);
        build(0, 8'h01, 0, 8'h00, 8'hFF, 8'h02, 8'h00, 8'h4A);
        push_ts(4'd1);
        send_range(1, 15, 0);
        gap(2);

        chk("queue_before_reset", q.size(), 0);
        build(0, 8'h07, 0, 8'h03, 8'h20, 8'h02, 8'h01, 8'h45);
        send_range(0, 9, 0);
        @(negedge clk);
        rst_n = 1'b0;
        rx_valid = 1'b0;
        #1;
        chk_zero("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        gap(2);
        h = '{e:1'b0, t:OS_NONE, ln:8'h0, lp:1'b0, la:8'h0, lap:1'b0, nf:8'h0, rt:8'h0, ct:8'h0, sk:3'd0, c:4'd0};
        build(0, 8'h01, 0, 8'h00, 8'hFF, 8'h02, 8'h00, 8'h4A);
        push_ts(4'd1);
        send_range(0, 15, 0);
        push_ts(4'd2);
        send_range(0, 15, 0);
        gap(6);

        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_ordered_set_detector.md
# rx_ordered_set_detector

Receive-side parser for 8b/10b-decoded Gen1/Gen2 symbol streams on a single lane. Sits between the lane's 8b/10b decoder and the LTSSM. Recognises TS1, TS2, SKP, EIOS and FTS ordered sets, built from the shared K-symbol codes, and extracts the TS1/TS2 fields. Keeps a count of consecutive identical training sets for LTSSM exit conditions.

## Interface
Parameters:
- MAX_SKP, 5: maximum SKP symbols accepted after a COM; one more is an error.
- CONSEC_W, 4: width of the consecutive-TS counter, which saturates.

Ports:
- clk, input, 1: symbol clock.
- rst_n, input, 1: asynchronous active-low reset.
- rx_valid, input, 1: rx_data/rx_is_k carry a symbol this cycle.
- rx_data, input, 8: decoded symbol.
- rx_is_k, input, 1: symbol is a K code.
- rx_code_err, input, 1: decoder disparity or code error on this symbol.
- os_valid, output, 1: one-cycle pulse; a complete ordered set was parsed.
- os_type, output, os_type_e: type of the set; held until the next os_valid.
- ts_link_num, output, 8: TS symbol 1.
- ts_link_pad, output, 1: symbol 1 was PAD (K23.7).
- ts_lane_num, output, 8: TS symbol 2.
- ts_lane_pad, output, 1: symbol 2 was PAD.
- ts_n_fts, output, 8: TS symbol 3.
- ts_rate_id, output, 8: TS symbol 4.
- ts_train_ctrl, output, 8: TS symbol 5.
- skp_count, output, 3: number of SKPs in the last SKP set.
- os_err, output, 1: one-cycle pulse; a malformed set was aborted.
- ts_consec_cnt, output, CONSEC_W: consecutive identical TS count.

## Operation
- Symbols are consumed only when rx_valid=1. rx_valid=0 holds all state; there is no timeout.
- FSM states: IDLE, TYPE, TS_BODY, SKP, EIOS_BODY, FTS_BODY.
- IDLE: COM (K28.5, is_k=1) → TYPE. Every other symbol is ignored as non-OS traffic.
- TYPE consumes symbol 1:
  - SKP (K28.0) → SKP, count=1.
  - IDL (K28.3) → EIOS_BODY, idx=2.
  - FTS (K28.1) → FTS_BODY, idx=2.
  - D-symbol or PAD → TS_BODY, capture link number, idx=2.
  - Any other K → error.
- TS_BODY, idx 2..15:
  - idx2: lane number, data or PAD.
  - idx3–5: must be data symbols; capture N_FTS, rate id and training control.
  - idx6: must be D10.2 (0x4A, TS1) or D5.2 (0x45, TS2); latch it as the identifier.
  - idx7–15: each must equal the latched identifier with is_k=0.
  - idx15 accepted → complete as TS1 or TS2.
- EIOS_BODY: three IDL total → complete EIOS. FTS_BODY: three FTS total → complete FTS.
- SKP state:
  - Each further SKP increments the count.
  - If count would exceed MAX_SKP → error.
  - The first non-SKP symbol completes the set with skp_count=count, and is then re-evaluated as if in IDLE in the same cycle. A COM goes to TYPE.
- Error on rx_code_err=1 in any non-IDLE state, or on an unexpected symbol. Action: os_err pulse, field outputs unchanged, go to IDLE. If the offending symbol is a valid COM, go to TYPE instead.
- rx_code_err in IDLE is ignored.
- Consecutive counter, updated on each completion:
  - TS whose type and all five fields (pad flags included) match the previous TS → increment, saturating.
  - A different TS → load 1.
  - SKP, EIOS and FTS leave it unchanged.
  - os_err → clear to 0.

## Timing
- Reset values: all outputs 0; os_type=OS_NONE; FSM in IDLE.
- Outputs are registered. os_valid, os_type and ts_* update the cycle after the final symbol of the set is accepted.
- SKP completion is signalled the cycle after the terminating non-SKP symbol.
- os_err asserts the cycle after the offending symbol.
- ts_consec_cnt updates in the same cycle as os_valid or os_err.
- os_valid and os_err are never asserted together.
- Back-to-back sets with no gap between them are supported. Throughput is 1 symbol per cycle.
- Reset asserted mid-set: the partial set is discarded and no pulse is emitted.

## Structure
- Add to register_pkg:
  - os_type_e: OS_NONE, OS_TS1, OS_TS2, OS_SKP, OS_EIOS, OS_FTS.
  - Constants TS1_ID=8'h4A and TS2_ID=8'h45.
- The K-symbol codes come from the existing k_symbols_e in register_pkg.
- One sub-module, ts_consec_counter. It holds the last-TS compare register and the saturating counter, and is reused later for per-lane LTSSM checks.

## Test plan
- COM, 0x01 (link 1), 0x00 (lane 0), 0xFF, 0x02, 0x00, then 10×0x4A → os_valid with OS_TS1, link=1, lane=0, n_fts=0xFF, rate=0x02. Repeat the same set 8 times → ts_consec_cnt=8.
- COM, PAD, PAD, 0x10, 0x02, 0x00, then 10×0x45 → OS_TS2, link_pad=1, lane_pad=1, n_fts=0x10. A following TS1 loads ts_consec_cnt=1.
- COM, 3×SKP, then COM → OS_SKP with skp_count=3, and the second COM starts a new set. COM followed by 6×SKP → os_err and ts_consec_cnt=0.
- COM, 3×IDL → OS_EIOS. COM, 3×FTS → OS_FTS. Insert rx_valid=0 gaps mid-set → same results, delayed accordingly.
- Error cases:
  - TS with symbol 9 = 0x4B → os_err, no os_valid.
  - rx_code_err on TS symbol 4 → os_err.
  - COM arriving at TS symbol 7 → os_err, then the new set parses correctly.
- Assert rst_n at TS symbol 10 → all outputs return to 0 and no os_valid appears. A clean TS after release is detected with ts_consec_cnt=1.
